m_data_mem: RTL and testbench

//  MEM-stage data memory: consumes the EX/MEM pipeline register outputs (ALU result as address,
//  rt value as store data, PC, decoded memory op) and produces the load value latched by the
//  MEM/WB register. Word-organised RAM with byte/halfword/word stores, sign/zero-extended

---
 rtl/m_data_mem_pkg.sv | 44 ++++
 rtl/m_data_mem_if.sv | 25 ++
 rtl/m_dm_ext.sv | 29 ++
 rtl/m_data_mem.sv | 84 ++++++++
 tb/tb_m_data_mem.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/m_data_mem_pkg.sv
// Shared definitions for the MEM-stage data memory: memory op encodings,
// default geometry and small op-classification helpers.
package m_data_mem_pkg;

    localparam int DEPTH_WORDS_DEF = 3072;
    localparam int IDX_W_DEF       = 12;

    // Memory op encodings, shared with the decoder/controller.
    typedef enum logic [3:0] {
        DM_NONE = 4'd0,
        DM_LW   = 4'd1,
        DM_LH   = 4'd2,
        DM_LHU  = 4'd3,
        DM_LB   = 4'd4,
        DM_LBU  = 4'd5,
        DM_SW   = 4'd6,
        DM_SH   = 4'd7,
        DM_SB   = 4'd8
    } dm_op_e;

    function automatic logic dm_is_load(input logic [3:0] op);
        case (op)
            DM_LW, DM_LH, DM_LHU, DM_LB, DM_LBU: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    function automatic logic dm_is_store(input logic [3:0] op);
        case (op)
            DM_SW, DM_SH, DM_SB: return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

    // Misalignment depends only on access size; byte accesses never fault.
    function automatic logic dm_misaligned(input logic [3:0] op, input logic [1:0] lane);
        case (op)
            DM_LW, DM_SW:          return lane != 2'b00;
            DM_LH, DM_LHU, DM_SH:  return lane[0];
            default:               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/m_data_mem_if.sv
// EX/MEM-to-data-memory bus: request fields from the pipeline register,
// load result and error flags back, plus the committed-store view used for
// the write log.
interface m_data_mem_if;
    logic [3:0]  mem_op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic        align_err;
    logic        range_err;
    logic        commit;
    logic [31:0] commit_addr;
    logic [31:0] commit_word;

    modport master (
        output mem_op, addr, wdata, pc,
        input  rdata, align_err, range_err, commit, commit_addr, commit_word
    );

    modport slave (
        input  mem_op, addr, wdata, pc,
        output rdata, align_err, range_err, commit, commit_addr, commit_word
    );
endinterface

// File: rtl/m_dm_ext.sv
// Load lane select and sign/zero extension for the data memory.
// Little-endian: lane 0 is bits 7:0, halfword at lane 2 is bits 31:16.
module m_dm_ext
    import m_data_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [3:0]  mem_op,
    output logic [31:0] load_val
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte/halfword, then extend according to the op.
    always_comb begin
        byte_sel = word[8*lane +: 8];
        half_sel = lane[1] ? word[31:16] : word[15:0];
        case (mem_op)
            DM_LW:   load_val = word;
            DM_LH:   load_val = {{16{half_sel[15]}}, half_sel};
            DM_LHU:  load_val = {16'h0000, half_sel};
            DM_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
            DM_LBU:  load_val = {24'h000000, byte_sel};
            default: load_val = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/m_data_mem.sv
// MEM-stage data memory: word-organised RAM with combinational reads,
// byte/halfword/word stores merged into the existing word on the rising
// edge, and alignment/range checking that suppresses faulting accesses.
module m_data_mem
    import m_data_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int IDX_W       = IDX_W_DEF
) (
    input  logic          clk,
    input  logic          reset,
    m_data_mem_if.slave   bus
);

    localparam logic [31:0] BYTE_LIMIT = 32'(4 * DEPTH_WORDS);

    logic [31:0]      mem [0:DEPTH_WORDS-1];
    logic             is_load;
    logic             is_store;
    logic             align_err;
    logic             range_err;
    logic             any_err;
    logic [IDX_W-1:0] idx;
    logic [31:0]      rd_word;
    logic [31:0]      ext_val;
    logic [31:0]      merged;
    logic             commit;

    // Classify the op and flag misaligned or out-of-range accesses.
    always_comb begin
        is_load   = dm_is_load(bus.mem_op);
        is_store  = dm_is_store(bus.mem_op);
        align_err = dm_misaligned(bus.mem_op, bus.addr[1:0]);
        range_err = (is_load || is_store) && (bus.addr >= BYTE_LIMIT);
        any_err   = align_err || range_err;
        idx       = bus.addr[IDX_W+1:2];
        // Out-of-range addresses never touch the array.
        rd_word   = range_err ? 32'h0000_0000 : mem[idx];
    end

    m_dm_ext u_ext (
        .word     (rd_word),
        .lane     (bus.addr[1:0]),
        .mem_op   (bus.mem_op),
        .load_val (ext_val)
    );

    // Merge the store lanes into the current word; untouched lanes keep their contents.
    always_comb begin
        merged = rd_word;
        case (bus.mem_op)
            DM_SW: merged = bus.wdata;
            DM_SH: begin
                if (bus.addr[1]) merged[31:16] = bus.wdata[15:0];
                else             merged[15:0]  = bus.wdata[15:0];
            end
            DM_SB: merged[8*bus.addr[1:0] +: 8] = bus.wdata[7:0];
            default: merged = rd_word;
        endcase
    end

    // A store commits only when it is error-free and not overridden by reset.
    always_comb begin
        commit          = is_store && !any_err && !reset;
        bus.rdata       = (is_load && !any_err) ? ext_val : 32'h0000_0000;
        bus.align_err   = align_err;
        bus.range_err   = range_err;
        bus.commit      = commit;
        bus.commit_addr = {bus.addr[31:2], 2'b00};
        bus.commit_word = merged;
    end

    // Reset clears every word; otherwise a committed store writes the merged word.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= 32'h0000_0000;
            end
        end else if (commit) begin
            mem[idx] <= merged;
        end
    end

endmodule

// File: tb/tb_m_data_mem.sv
// Scoreboard bench for m_data_mem: a byte-addressed reference memory
// predicts every cycle's load value, flags and committed store; a monitor
// on the falling edge compares the DUT against the queued predictions.
module tb_m_data_mem;

    localparam int NBYTES = 4 * 3072;

    logic clk = 1'b0;
    logic reset;
    m_data_mem_if bus ();

    m_data_mem #(.DEPTH_WORDS(3072), .IDX_W(12)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        al;
        logic        rg;
        logic        cm;
        logic [31:0] caddr;
        logic [31:0] cword;
        logic [31:0] pc;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  ref_mem [NBYTES];
    int          total = 0;
    int          bad = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endfunction

    function automatic logic [31:0] ref_read(input int a, input int n);
        logic [31:0] v = 0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[a + k];
        return v;
    endfunction

    // Apply one cycle of stimulus, predict the response and advance the model.
    task automatic issue(input logic rst, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] p, input string nm);
        exp_t e;
        bit   ld, st, sgn;
        int   sz;
        logic [31:0] v;
        @(posedge clk);
        #1;
        reset = rst; bus.mem_op = op; bus.addr = a; bus.wdata = wd; bus.pc = p;
        ld  = (op >= 1 && op <= 5);
        st  = (op >= 6 && op <= 8);
        sz  = (op == 1 || op == 6) ? 4 : (op == 2 || op == 3 || op == 7) ? 2 : 1;
        sgn = (op == 2 || op == 4);
        e.name  = nm;
        e.pc    = p;
        e.rg    = (ld || st) && (a >= NBYTES);
        e.al    = (ld || st) && ((a % sz) != 0);
        e.rdata = 0;
        if (ld && !e.rg && !e.al) begin
            v = ref_read(int'(a), sz);
            if (sgn && sz == 2) v = {{16{v[15]}}, v[15:0]};
            if (sgn && sz == 1) v = {{24{v[7]}}, v[7:0]};
            e.rdata = v;
        end
        e.cm    = st && !e.rg && !e.al && !rst;
        e.caddr = a & 32'hFFFF_FFFC;
        e.cword = 0;
        if (rst) begin
            for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'h00;
        end else if (e.cm) begin
            for (int k = 0; k < sz; k++) ref_mem[int'(a) + k] = wd[8*k +: 8];
            e.cword = ref_read(int'(e.caddr), 4);
        end
        q.push_back(e);
    endtask

    // Compare DUT outputs against the oldest prediction on the opposite edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk({e.name, ".rdata"}, bus.rdata, e.rdata);
            chk({e.name, ".align"}, 32'(bus.align_err), 32'(e.al));
            chk({e.name, ".range"}, 32'(bus.range_err), 32'(e.rg));
            chk({e.name, ".commit"}, 32'(bus.commit), 32'(e.cm));
            if (e.cm) begin
                chk({e.name, ".caddr"}, bus.commit_addr, e.caddr);
                chk({e.name, ".cword"}, bus.commit_word, e.cword);
            end
            if (bus.commit === 1'b1 && reset === 1'b0)
                $display("@%h: *%h <= %h", bus.pc, bus.commit_addr, bus.commit_word);
        end
    end

    initial begin
        int r;
        logic [31:0] a;
        reset = 1'b1; bus.mem_op = 4'd0; bus.addr = 0; bus.wdata = 0; bus.pc = 0;
        for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'h00;

        // Reset then read
        issue(1, 0, 0, 0, 0, "rst0");
        issue(1, 0, 0, 0, 0, "rst1");
        issue(0, 1, 32'h10, 0, 32'h100, "lw_after_reset");

        // Word store then lane loads
        issue(0, 6, 32'h20, 32'h1234_5678, 32'h104, "sw20");
        issue(0, 4, 32'h20, 0, 32'h108, "lb20");
        issue(0, 4, 32'h23, 0, 32'h10C, "lb23");
        issue(0, 5, 32'h23, 0, 32'h110, "lbu23");
        issue(0, 2, 32'h22, 0, 32'h114, "lh22");

        // Partial merges
        issue(0, 8, 32'h21, 32'hFFFF_FF80, 32'h118, "sb21");
        issue(0, 1, 32'h20, 0, 32'h11C, "lw20_a");
        issue(0, 4, 32'h21, 0, 32'h120, "lb21");
        issue(0, 7, 32'h22, 32'h0000_ABCD, 32'h124, "sh22");
        issue(0, 1, 32'h20, 0, 32'h128, "lw20_b");
        issue(0, 2, 32'h22, 0, 32'h12C, "lh22_b");
        issue(0, 3, 32'h22, 0, 32'h130, "lhu22");

        // Alignment and range faults
        issue(0, 6, 32'h22, 32'h1111_1111, 32'h134, "sw22_mis");
        issue(0, 7, 32'h21, 32'h2222_2222, 32'h138, "sh21_mis");
        issue(0, 1, 32'h20, 0, 32'h13C, "lw20_c");
        issue(0, 1, 32'h2E00, 0, 32'h140, "lw2e00");
        issue(0, 1, 32'h3000, 0, 32'h144, "lw3000_rng");
        issue(0, 3, 32'h3001, 0, 32'h148, "lhu3001_both");
        issue(0, 8, 32'h2FFF, 32'h0000_00A5, 32'h14C, "sb2fff");
        issue(0, 8, 32'h3000, 32'h0000_005A, 32'h150, "sb3000_rng");
        issue(0, 1, 32'h2FFC, 0, 32'h154, "lw2ffc");
        issue(0, 0, 32'h0000_0003, 0, 32'h158, "none_mis");
        issue(0, 4'hF, 32'hFFFF_FFFF, 0, 32'h15C, "undef_op");

        // Read-after-write and back-to-back merges
        issue(0, 1, 32'h40, 0, 32'h160, "lw40_old");
        issue(0, 6, 32'h40, 32'hDEAD_BEEF, 32'h164, "sw40");
        issue(0, 1, 32'h40, 0, 32'h168, "lw40_new");
        issue(0, 8, 32'h40, 32'h11, 32'h16C, "sb40");
        issue(0, 8, 32'h41, 32'h22, 32'h170, "sb41");
        issue(0, 1, 32'h40, 0, 32'h174, "lw40_merge");

        // Reset in the middle of a store sequence
        issue(0, 6, 32'h0, 32'hFFFF_FFFF, 32'h178, "sw0");
        issue(0, 6, 32'h2FFC, 32'hFFFF_FFFF, 32'h17C, "sw2ffc");
        issue(1, 6, 32'h0, 32'h1234_0000, 32'h180, "sw_under_reset");
        issue(0, 1, 32'h0, 0, 32'h184, "lw0_post");
        issue(0, 1, 32'h2FFC, 0, 32'h188, "lw2ffc_post");

        // Randomized traffic concentrated on a few words near both ends
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      a = 32'($urandom_range(0, 127));
            else if (r < 9) a = 32'(12272 + $urandom_range(0, 31));
            else            a = $urandom;
            issue(($urandom_range(0, 49) == 0), 4'($urandom_range(0, 15)), a, $urandom,
                  32'h1000 + 32'(4 * n), "rand");
        end

        @(posedge clk);
        #1;
        reset = 1'b0; bus.mem_op = 4'd0;
        for (int w = 0; w < 10 && q.size() > 0; w++) @(posedge clk);
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain actual=%0d expected=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
